md_unit: RTL

- Multiply/divide unit in the EX stage of the 5-stage pipelined CPU, fed directly by the ID/EX pipeline register.
- Latches the two source operands on a start pulse and runs a multi-cycle mult/multu/div/divu.
- Holds the HI/LO result registers, which mfhi/mflo read.
- Exposes busy to the hazard unit, which stalls F/D while an HI/LO-touching instruction waits.

---
 rtl/md_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers for the EX stage.
// Optional in-flight cancel port is enabled by defining MD_CANCEL_EN.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  md_op,
`ifdef MD_CANCEL_EN
    input  logic        cancel,
`endif
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_NOP0 = 3'd0,
        OP_MULT = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV  = 3'd3,
        OP_DIVU = 3'd4,
        OP_MTHI = 3'd5,
        OP_MTLO = 3'd6,
        OP_NOP7 = 3'd7
    } op_e;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0]   a_q, a_n;
    logic [31:0]   b_q, b_n;
    logic          mul_q, mul_n;
    logic          sgn_q, sgn_n;
    logic [31:0]   hi_q, hi_n;
    logic [31:0]   lo_q, lo_n;
    op_e           op_in;

    logic [63:0]   prod;
    logic [31:0]   a_mag, b_mag;
    logic [31:0]   uq, ur;
    logic [31:0]   quot, rem;

    assign op_in = op_e'(md_op);

    // Results are formed combinationally from the latched operands and only
    // written into HI/LO on the final RUN edge.
    always_comb begin
        if (sgn_q) begin
            prod = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        end else begin
            prod = {32'b0, a_q} * {32'b0, b_q};
        end
    end

    // Signed division runs on magnitudes; quotient truncates toward zero and
    // the remainder follows the dividend. 0x80000000 / -1 wraps naturally.
    always_comb begin
        a_mag = (sgn_q && a_q[31]) ? (~a_q + 32'd1) : a_q;
        b_mag = (sgn_q && b_q[31]) ? (~b_q + 32'd1) : b_q;
        uq    = '0;
        ur    = '0;
        if (b_mag != '0) begin
            uq = a_mag / b_mag;
            ur = a_mag % b_mag;
        end
        quot  = (sgn_q && (a_q[31] ^ b_q[31])) ? (~uq + 32'd1) : uq;
        rem   = (sgn_q && a_q[31]) ? (~ur + 32'd1) : ur;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        a_n     = a_q;
        b_n     = b_q;
        mul_n   = mul_q;
        sgn_n   = sgn_q;
        hi_n    = hi_q;
        lo_n    = lo_q;

        unique case (state)
            IDLE: begin
                if (start) begin
                    case (op_in)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            a_n     = a;
                            b_n     = b;
                            mul_n   = (op_in == OP_MULT) || (op_in == OP_MULTU);
                            sgn_n   = (op_in == OP_MULT) || (op_in == OP_DIV);
                            cnt_n   = mul_n ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                            state_n = RUN;
                        end
                        OP_MTHI: hi_n = a;
                        OP_MTLO: lo_n = a;
                        default: ;
                    endcase
                end
            end

            RUN: begin
`ifdef MD_CANCEL_EN
                if (cancel) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else
`endif
                if (cnt == CW'(1)) begin
                    if (mul_q) begin
                        hi_n = prod[63:32];
                        lo_n = prod[31:0];
                    end else if (b_q != '0) begin
                        hi_n = rem;
                        lo_n = quot;
                    end
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            mul_q <= 1'b0;
            sgn_q <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            a_q   <= a_n;
            b_q   <= b_n;
            mul_q <= mul_n;
            sgn_q <= sgn_n;
            hi_q  <= hi_n;
            lo_q  <= lo_n;
        end
    end

    assign busy = (state == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
